mask_threshold_ctrl: RTL

- Frame-level controller for the luma masking stage.
- Watches the 1-bit mask stream and its pixel coordinates, and counts masked pixels per frame.
- At end of frame it closes the loop: it adjusts the luma threshold it drives into the masking stage, so the masked-pixel population tracks a programmable target.
- Sits directly downstream of the masking datapath; its threshold output feeds back into that datapath's compare.

---
 rtl/mask_ctrl_pkg.sv | 22 ++
 rtl/sat_counter.sv | 26 ++
 rtl/mask_threshold_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mask_ctrl_pkg.sv
// Shared types and widths for the luma-mask threshold controller.
package mask_ctrl_pkg;

    localparam int COUNT_W  = 20;
    localparam int THRESH_W = 10;
    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EVAL,
        COMMIT
    } state_t;

    typedef enum logic [1:0] {
        HOLD,
        UP,
        DOWN
    } decision_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load; clear has priority over load.
module sat_counter #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mask_threshold_ctrl.sv
// Counts masked pixels per frame and nudges the masking threshold toward a target population.
module mask_threshold_ctrl
    import mask_ctrl_pkg::*;
#(
    parameter int H_MAX       = 1023,
    parameter int V_MAX       = 767,
    parameter int INIT_THRESH = 63,
    parameter int STEP        = 4
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                data_valid_in,
    input  logic                mask_in,
    input  logic [HCOUNT_W-1:0] hcount_in,
    input  logic [VCOUNT_W-1:0] vcount_in,
    input  logic [COUNT_W-1:0]  target_in,
    input  logic [15:0]         hyst_in,
    input  logic                manual_in,
    input  logic [THRESH_W-1:0] manual_thresh_in,
    input  logic                freeze_in,
    output logic [THRESH_W-1:0] threshold_out,
    output logic                update_out,
    output logic [COUNT_W-1:0]  frame_count_out,
    output logic                busy_out
);

    localparam logic [THRESH_W-1:0] STEP_T = THRESH_W'(STEP);

    state_t              state;
    state_t              state_next;
    decision_t           decision;
    logic                first_beat;
    logic                last_beat;
    logic                cnt_clear;
    logic                cnt_load;
    logic                cnt_inc;
    logic [COUNT_W-1:0]  count;
    logic [COUNT_W:0]    hi_wide;
    logic [COUNT_W-1:0]  hi;
    logic [COUNT_W-1:0]  lo;
    logic [COUNT_W-1:0]  hyst_ext;
    logic [THRESH_W:0]   thr_sum;
    logic [THRESH_W-1:0] thr_up;
    logic [THRESH_W-1:0] thr_down;
    logic [THRESH_W-1:0] thr_next;

    assign first_beat = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
    assign last_beat  = data_valid_in && (hcount_in == HCOUNT_W'(H_MAX))
                                      && (vcount_in == VCOUNT_W'(V_MAX));

    sat_counter #(
        .WIDTH(COUNT_W)
    ) u_count (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_value (COUNT_W'(mask_in)),
        .inc        (cnt_inc),
        .count      (count)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A (0,0) beat always restarts the count, so a resync mid-frame needs no extra state.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (first_beat) begin
                    cnt_load   = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (first_beat) begin
                    cnt_load = 1'b1;
                end else if (data_valid_in) begin
                    cnt_inc = mask_in;
                    if (last_beat) begin
                        state_next = EVAL;
                    end
                end
            end
            EVAL: begin
                state_next = COMMIT;
            end
            COMMIT: begin
                cnt_clear  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign hyst_ext = COUNT_W'(hyst_in);
    assign hi_wide  = {1'b0, target_in} + {1'b0, hyst_ext};
    assign hi       = hi_wide[COUNT_W] ? {COUNT_W{1'b1}} : hi_wide[COUNT_W-1:0];
    assign lo       = (target_in > hyst_ext) ? (target_in - hyst_ext) : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            decision <= HOLD;
        end else if (state == EVAL) begin
            if (count > hi) begin
                decision <= UP;
            end else if (count < lo) begin
                decision <= DOWN;
            end else begin
                decision <= HOLD;
            end
        end
    end

    assign thr_sum  = {1'b0, threshold_out} + {1'b0, STEP_T};
    assign thr_up   = thr_sum[THRESH_W] ? {THRESH_W{1'b1}} : thr_sum[THRESH_W-1:0];
    assign thr_down = (threshold_out >= STEP_T) ? (threshold_out - STEP_T) : '0;

    always_comb begin
        thr_next = threshold_out;
        if (manual_in) begin
            thr_next = manual_thresh_in;
        end else if (!freeze_in) begin
            case (decision)
                UP:      thr_next = thr_up;
                DOWN:    thr_next = thr_down;
                default: thr_next = threshold_out;
            endcase
        end
    end

    // busy_out decodes the next state so it lines up with the state register itself.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            threshold_out   <= THRESH_W'(INIT_THRESH);
            frame_count_out <= '0;
            update_out      <= 1'b0;
            busy_out        <= 1'b0;
        end else begin
            update_out <= (state == COMMIT);
            busy_out   <= (state_next != IDLE);
            if (state == COMMIT) begin
                frame_count_out <= count;
                threshold_out   <= thr_next;
            end
        end
    end

endmodule
